// File: rtl/rr_gap_arbiter_pkg.sv
// Shared types and parameter limits for the round-robin gap arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rr_gap_arbiter_pkg;

    // Arbiter FSM: GAP is the forced idle cycle that follows every grant.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    // Legal parameter ranges.
    localparam int N_REQ_MIN    = 2;
    localparam int N_REQ_MAX    = 16;
    localparam int HOLD_MAX_MIN = 1;
    localparam int HOLD_MAX_MAX = 255;

endpackage

// File: rtl/rr_gap_arbiter_pick.sv
// Combinational round-robin picker: first set request at or after last+1, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; valid is low when no request is present.
// Ports: req (request vector), last (previous winner), valid (a winner exists), idx (winner).
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic             valid,
    output logic [IW-1:0]    idx
);

    int          w_cand;
    logic [IW-1:0] w_cand_idx;

    // Walk offsets 1..N_REQ from last; offset N_REQ lands back on last itself,
    // so the previous winner is considered only after every other requester.
    always_comb begin
        valid      = 1'b0;
        idx        = '0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand     = (int'(last) + k) % N_REQ;
            w_cand_idx = w_cand[IW-1:0];
            if (!valid && req[w_cand_idx]) begin
                valid = 1'b1;
                idx   = w_cand_idx;
            end
        end
    end

endmodule

// File: rtl/rr_gap_arbiter.sv
// Round-robin owner arbiter with one idle gap cycle between grants and a hold-time limit.
// Latency: grant registered 1 cycle after req is sampled; release 1 cycle after done is sampled.
// Backpressure: requests are level-held; losers simply wait, owner releases via done or timeout.
// Ports: clk, rst (sync, active-high), req/done [N_REQ], gnt [N_REQ] one-hot-or-zero,
//        gnt_id (owner index, 0 when idle), busy (|gnt), timeout (1-cycle revoke pulse).
// Optional macro RR_GAP_ARBITER_ASSERTIONS_EN compiles in embedded temporal assertions.
module rr_gap_arbiter
    import rr_gap_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         done,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     busy,
    output logic                     timeout
);

    localparam int IW = $clog2(N_REQ);
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(HOLD_MAX);

    if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX ||
        HOLD_MAX < HOLD_MAX_MIN || HOLD_MAX > HOLD_MAX_MAX) begin : g_param_check
        $error("rr_gap_arbiter: parameter out of range");
    end

    arb_state_e       r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [IW-1:0]    r_gnt_id;
    logic [IW-1:0]    r_last;
    logic [HW-1:0]    r_hcnt;
    logic             r_busy;
    logic             r_timeout;

    arb_state_e       w_state_nxt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [IW-1:0]    w_gnt_id_nxt;
    logic [IW-1:0]    w_last_nxt;
    logic [HW-1:0]    w_hcnt_nxt;
    logic             w_timeout_nxt;

    logic             w_pick_vld;
    logic [IW-1:0]    w_pick_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req   (req),
        .last  (r_last),
        .valid (w_pick_vld),
        .idx   (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_last    <= IW'(N_REQ - 1);
            r_hcnt    <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_last    <= w_last_nxt;
            r_hcnt    <= w_hcnt_nxt;
            r_busy    <= |w_gnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_last_nxt    = r_last;
        w_hcnt_nxt    = r_hcnt;
        w_timeout_nxt = 1'b0;

        case (r_state)
            IDLE, GAP: begin
                // IDLE and GAP share the pick; GAP only differs in that gnt
                // was just dropped, which guarantees the idle cycle.
                w_state_nxt  = IDLE;
                w_gnt_nxt    = '0;
                w_gnt_id_nxt = '0;
                w_hcnt_nxt   = '0;
                if (w_pick_vld) begin
                    w_state_nxt             = GRANT;
                    w_gnt_nxt[w_pick_idx]   = 1'b1;
                    w_gnt_id_nxt            = w_pick_idx;
                    w_last_nxt              = w_pick_idx;
                    w_hcnt_nxt              = HW'(1);
                end
            end
            GRANT: begin
                if (done[r_gnt_id] || r_hcnt == HOLD_LIMIT) begin
                    w_state_nxt   = GAP;
                    w_gnt_nxt     = '0;
                    w_gnt_id_nxt  = '0;
                    w_hcnt_nxt    = '0;
                    // A release in the final hold cycle is a normal release.
                    w_timeout_nxt = !done[r_gnt_id];
                end else begin
                    w_hcnt_nxt = r_hcnt + HW'(1);
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_gnt_nxt    = '0;
                w_gnt_id_nxt = '0;
                w_hcnt_nxt   = '0;
            end
        endcase
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign busy    = r_busy;
    assign timeout = r_timeout;

`ifdef RR_GAP_ARBITER_ASSERTIONS_EN
    default clocking cb_arb @(posedge clk);
    endclocking

    default disable iff (rst);

    a_gnt_onehot0: assert property ($onehot0(gnt));

    a_hold_bound: assert property (busy && !$past(busy) |-> ##[1:HOLD_MAX] !busy);

    a_gap_min: assert property ($fell(busy) |-> !busy);

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_done_chk
        a_done_owner: assert property (done[gi] |-> gnt[gi]);
    end

    a_timeout_idle: assert property (timeout |-> !busy);
`endif

endmodule

// File: tb/tb_rr_gap_arbiter.sv
module tb_rr_gap_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int n_cmp;
    int n_mis;

    // Scoreboard: expected {gnt, gnt_id, busy, timeout} pushed when the cycle
    // is driven, popped after the edge that produces it.
    logic [7:0] exp_q[$];
    string      tag_q[$];

    rr_gap_arbiter #(
        .N_REQ    (4),
        .HOLD_MAX (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run, required end before 200000");
        $fatal(1, "watchdog expired");
    end

    // Drive one cycle of inputs, then check the registered outputs after the edge.
    task automatic step(input logic s_rst, input logic [3:0] s_req, input logic [3:0] s_done,
                        input logic [3:0] e_gnt, input logic [1:0] e_id, input logic e_to,
                        input string tag);
        logic [7:0] obs;
        logic [7:0] expv;
        string      t;
        rst  = s_rst;
        req  = s_req;
        done = s_done;
        exp_q.push_back({e_gnt, e_id, (e_gnt != 4'b0000), e_to});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        expv = exp_q.pop_front();
        t    = tag_q.pop_front();
        obs  = {gnt, gnt_id, busy, timeout};
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed gnt/id/busy/to=%b_%0d_%b_%b required %b_%0d_%b_%b",
                   t, obs[7:4], obs[3:2], obs[1], obs[0],
                   expv[7:4], expv[3:2], expv[1], expv[0]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst   = 1'b1;
        req   = '0;
        done  = '0;
        @(posedge clk);
        #1;

        // Reset state, and reset dominating live requests.
        step(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "reset_idle");
        step(1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 0, "reset_with_req");

        // Single requester 2: grant, hold, release, one gap, re-grant.
        step(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "single_grant");
        step(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "single_hold2");
        step(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "single_hold3");
        step(0, 4'b0100, 4'b0100, 4'b0000, 2'd0, 0, "single_done_gap");
        step(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "single_regrant");
        step(0, 4'b0000, 4'b0100, 4'b0000, 2'd0, 0, "single_release2");
        step(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "single_idle");

        // Fresh reset, then all four requesting, each releasing in its first cycle.
        step(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "rr_reset");
        step(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0, "rr_gnt0");
        step(0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 0, "rr_gap0");
        step(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 0, "rr_gnt1");
        step(0, 4'b1111, 4'b0010, 4'b0000, 2'd0, 0, "rr_gap1");
        step(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 0, "rr_gnt2");
        step(0, 4'b1111, 4'b0100, 4'b0000, 2'd0, 0, "rr_gap2");
        step(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 0, "rr_gnt3");
        step(0, 4'b1111, 4'b1000, 4'b0000, 2'd0, 0, "rr_gap3");
        step(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0, "rr_gnt0_wrap");
        step(0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 0, "rr_gap_wrap");
        step(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "rr_idle");

        // Stuck owner 1: exactly 8 grant cycles, then a timeout pulse in the gap.
        step(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 0, "stuck_hold1");
        for (int i = 2; i <= 8; i++)
            step(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 0, $sformatf("stuck_hold%0d", i));
        step(0, 4'b1010, 4'b0000, 4'b0000, 2'd0, 1, "stuck_timeout");
        step(0, 4'b1010, 4'b0000, 4'b1000, 2'd3, 0, "stuck_next_gnt3");

        // Non-owner done while requester 3 holds the grant is ignored.
        step(0, 4'b1010, 4'b0010, 4'b1000, 2'd3, 0, "foreign_done_ignored");
        step(0, 4'b0000, 4'b1000, 4'b0000, 2'd0, 0, "owner3_release");
        step(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "idle_after3");

        // Owner drops req and releases in the final hold cycle: no timeout.
        step(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 0, "edge_hold1");
        for (int i = 2; i <= 8; i++)
            step(0, 4'b0000, 4'b0000, 4'b0001, 2'd0, 0, $sformatf("edge_hold%0d", i));
        step(0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 0, "edge_done_no_timeout");
        step(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "edge_idle_no_timeout");

        // Reset in the third grant cycle: outputs clear, priority returns to 0.
        step(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "rst_mid_c1");
        step(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "rst_mid_c2");
        step(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "rst_mid_c3");
        step(1, 4'b0100, 4'b0000, 4'b0000, 2'd0, 0, "rst_mid_clear");
        step(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0, "rst_mid_gnt0");
        step(0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 0, "rst_mid_gap");
        step(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "rst_mid_idle");

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL scoreboard_drain: observed %0d left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
